// File: rtl/link_responder_pkg.sv
// Shared types and default timing constants for the link responder.
package link_responder_pkg;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_CAPT = 2'd1,
    O_ACK  = 2'd2,
    O_WAIT = 2'd3
  } out_state_e;

  typedef enum logic [1:0] {
    I_IDLE  = 2'd0,
    I_SETUP = 2'd1,
    I_PULSE = 2'd2,
    I_WAIT  = 2'd3
  } in_state_e;

  localparam int unsigned DEF_PULSE_LEN = 4;
  localparam int unsigned DEF_SETUP_LEN = 2;

endpackage

// File: rtl/link_byte_fifo.sv
// First-word fall-through byte FIFO; pointers carry one extra wrap bit.
module link_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  mem_q [DEPTH];
  logic        empty, do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign valid_o = ~empty;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/link_responder.sv
// Flag-handshake responder between a peer CPU's I/O registers and local byte streams.
// Optional feature: define LINK_LOOPBACK_EN to echo received peer bytes back to the peer.
module link_responder
  import link_responder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PULSE_LEN  = DEF_PULSE_LEN,
  parameter int unsigned SETUP_LEN  = DEF_SETUP_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] outr,
  input  logic       fg_out,
  output logic       fg_out_set_n,
  input  logic       fg_in,
  output logic       fg_in_set_n,
  output logic [7:0] inpr,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_LEN - 1);

  logic fo_meta_q, fo_s_q, fi_meta_q, fi_s_q;

  out_state_e o_state_q, o_state_d;
  logic [3:0] o_cnt_q, o_cnt_d;
  in_state_e  i_state_q, i_state_d;
  logic [3:0] i_cnt_q, i_cnt_d;
  logic       i_seen_q, i_seen_d;
  logic [7:0] inpr_q, inpr_d;

  logic       push, pop, fifo_valid, fifo_full, in_ready, src_valid;
  logic [7:0] fifo_head, src_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fo_meta_q <= 1'b1;
      fo_s_q    <= 1'b1;
      fi_meta_q <= 1'b1;
      fi_s_q    <= 1'b1;
      o_state_q <= O_IDLE;
      o_cnt_q   <= '0;
      i_state_q <= I_IDLE;
      i_cnt_q   <= '0;
      i_seen_q  <= 1'b0;
      inpr_q    <= '0;
    end else begin
      fo_meta_q <= fg_out;
      fo_s_q    <= fo_meta_q;
      fi_meta_q <= fg_in;
      fi_s_q    <= fi_meta_q;
      o_state_q <= o_state_d;
      o_cnt_q   <= o_cnt_d;
      i_state_q <= i_state_d;
      i_cnt_q   <= i_cnt_d;
      i_seen_q  <= i_seen_d;
      inpr_q    <= inpr_d;
    end
  end

  // Set pulses decode straight from state so reset releases them without waiting for a clock.
  always_comb begin
    o_state_d    = o_state_q;
    o_cnt_d      = o_cnt_q;
    push         = 1'b0;
    fg_out_set_n = 1'b1;
    case (o_state_q)
      O_IDLE: if (!fo_s_q && !fifo_full) o_state_d = O_CAPT;
      O_CAPT: begin
        push      = 1'b1;
        o_cnt_d   = '0;
        o_state_d = O_ACK;
      end
      O_ACK: begin
        fg_out_set_n = 1'b0;
        if (o_cnt_q == PULSE_LAST) o_state_d = O_WAIT;
        else                       o_cnt_d   = o_cnt_q + 4'd1;
      end
      O_WAIT: if (fo_s_q) o_state_d = O_IDLE;
      default: o_state_d = O_IDLE;
    endcase
  end

  always_comb begin
    i_state_d   = i_state_q;
    i_cnt_d     = i_cnt_q;
    i_seen_d    = i_seen_q;
    inpr_d      = inpr_q;
    in_ready    = 1'b0;
    fg_in_set_n = 1'b1;
    case (i_state_q)
      I_IDLE: begin
        in_ready = ~fi_s_q;
        if (src_valid && in_ready) begin
          inpr_d    = src_byte;
          i_cnt_d   = '0;
          i_seen_d  = 1'b0;
          i_state_d = I_SETUP;
        end
      end
      I_SETUP: begin
        if (i_cnt_q == SETUP_LAST) begin
          i_cnt_d   = '0;
          i_state_d = I_PULSE;
        end else begin
          i_cnt_d = i_cnt_q + 4'd1;
        end
      end
      I_PULSE: begin
        fg_in_set_n = 1'b0;
        if (i_cnt_q == PULSE_LAST) i_state_d = I_WAIT;
        else                       i_cnt_d   = i_cnt_q + 4'd1;
      end
      I_WAIT: begin
        // Peer consumption is a full rise-then-fall of its input flag.
        if (fi_s_q)        i_seen_d  = 1'b1;
        else if (i_seen_q) i_state_d = I_IDLE;
      end
      default: i_state_d = I_IDLE;
    endcase
  end

  assign inpr    = inpr_q;
  assign rx_byte = fifo_head;

`ifdef LINK_LOOPBACK_EN
  logic unused_lb;
  assign unused_lb = ^{tx_byte, tx_valid, rx_ready};
  assign src_byte  = fifo_head;
  assign src_valid = fifo_valid;
  assign pop       = fifo_valid & in_ready;
  assign rx_valid  = 1'b0;
  assign tx_ready  = 1'b0;
`else
  assign src_byte  = tx_byte;
  assign src_valid = tx_valid;
  assign pop       = fifo_valid & rx_ready;
  assign rx_valid  = fifo_valid;
  assign tx_ready  = in_ready;
`endif

  link_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (outr),
    .pop_i  (pop),
    .data_o (fifo_head),
    .valid_o(fifo_valid),
    .full_o (fifo_full)
  );

endmodule

// File: doc/link_responder.md
LINK_RESPONDER -- requirements
Module: link_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: depth of the received-byte FIFO; power of two, 2..16.
REQ-002 Parameter PULSE_LEN, default 4: clk cycles a *_set_n pulse is held low; range 1..15.
REQ-003 Parameter SETUP_LEN, default 2: clk cycles inpr is stable before fg_in_set_n falls; range 1..7.
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 outr  input  8  peer CPU output register.
REQ-007 fg_out  input  1  peer output flag; 0 means a byte is pending.
REQ-008 fg_out_set_n  output  1  active-low pulse that sets the peer fg_out.
REQ-009 fg_in  input  1  peer input flag; 1 means the peer has not yet consumed inpr.
REQ-010 fg_in_set_n  output  1  active-low pulse that sets the peer fg_in.
REQ-011 inpr  output  8  byte presented to the peer input register.
REQ-012 rx_byte  output  8  head of the received FIFO; rx_valid  output  1; rx_ready  input  1.
REQ-013 tx_byte  input  8; tx_valid  input  1; tx_ready  output  1  local byte to send to the peer.

Function
REQ-014 fg_out and fg_in SHALL each pass through a two-flop synchronizer; all decisions use the synchronized values (fo_s, fi_s).
REQ-015 Output path states: O_IDLE, O_CAPT, O_ACK, O_WAIT.
REQ-016 O_IDLE -> O_CAPT when fo_s==0 and the FIFO is not full; if the FIFO is full, stay in O_IDLE and hold fg_out_set_n=1 (backpressure).
REQ-017 O_CAPT: sample outr into the FIFO for exactly one cycle, then go to O_ACK.
REQ-018 O_ACK: drive fg_out_set_n=0 for PULSE_LEN cycles, then go to O_WAIT.
REQ-019 O_WAIT -> O_IDLE when fo_s==1; a byte is never captured twice per fg_out low period.
REQ-020 The FIFO is first-word fall-through: rx_valid=1 when non-empty; a pop occurs when rx_valid&rx_ready.
REQ-021 Simultaneous push and pop with the FIFO full is not possible (push is gated by not-full); with the FIFO empty, the push wins and rx_valid rises the next cycle.
REQ-022 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
REQ-023 Input path states: I_IDLE, I_SETUP, I_PULSE, I_WAIT.
REQ-024 I_IDLE: tx_ready=1 only when fi_s==0; on tx_valid&tx_ready, latch tx_byte into inpr and go to I_SETUP.
REQ-025 I_SETUP: hold for SETUP_LEN cycles, then go to I_PULSE.
REQ-026 I_PULSE: drive fg_in_set_n=0 for PULSE_LEN cycles, then go to I_WAIT.
REQ-027 I_WAIT: wait until fi_s==1 and then fi_s==0 (the peer has consumed the byte), then go to I_IDLE; inpr holds its value until the next latch.
REQ-028 The two paths are independent and may be active in the same cycle.

Reset
REQ-029 While rst_n=0: both FSMs in idle, FIFO empty, rx_valid=0, tx_ready=0, fg_out_set_n=1, fg_in_set_n=1, inpr=8'h00, synchronizers=1.
REQ-030 Reset asserted mid-pulse SHALL release *_set_n to 1 immediately (asynchronously); a partially captured byte is discarded.

Configuration
REQ-031 With LINK_LOOPBACK_EN defined, the FIFO head SHALL feed the input path in place of tx_byte/tx_valid; tx_ready=0, rx_valid=0, and each peer output byte is echoed back to the peer input.
REQ-032 Without LINK_LOOPBACK_EN, behaviour is as in REQ-012/013 and no loopback logic is present.

Structure
REQ-033 Shared package: output-path state encoding (2 bits), input-path state encoding (2 bits), and the default PULSE_LEN/SETUP_LEN constants.
REQ-034 The FIFO SHALL be a sub-module named link_byte_fifo (parameter DEPTH, width 8); the FSMs remain in link_responder.

Verification
REQ-035 fg_out falls with outr=8'hA5 -> after 2+1 cycles a PULSE_LEN-cycle low on fg_out_set_n; rx_byte=8'hA5, rx_valid=1.
REQ-036 Peer sends 5 bytes 01..05 with rx_ready=0, FIFO_DEPTH=4 -> 4 bytes stored, 5th ack withheld until one pop; after the pop, 8'h05 is accepted and order is preserved.
REQ-037 tx_byte=8'h3C, tx_valid=1, fg_in=0 -> inpr=8'h3C, SETUP_LEN cycles later fg_in_set_n low for PULSE_LEN cycles; tx_ready stays 0 until fg_in goes 1 then 0.
REQ-038 Attempt to send while fg_in is held 1 -> tx_ready=0 and no pulse until fg_in=0.
REQ-039 rst_n low during O_ACK -> fg_out_set_n=1 in the same cycle, FIFO empty, FSM in O_IDLE after release.
REQ-040 LINK_LOOPBACK_EN: peer outputs 8'h7E -> fg_out_set_n pulse, then inpr=8'h7E with an fg_in_set_n pulse; rx_valid stays 0.
